// File: rtl/rob_pkg.sv
// Shared widths and types for the multiport reorder buffer.
// Defaults describe the standard 16-entry configuration.
package rob_pkg;

  localparam int unsigned ROB_DEPTH  = 16;
  localparam int unsigned ROB_DATA_W = 16;
  localparam int unsigned ROB_AREG_W = 4;
  localparam int unsigned IDX_W      = $clog2(ROB_DEPTH);

  typedef logic [IDX_W-1:0] rob_tag_t;
  typedef logic [IDX_W:0]   rob_ptr_t;

  typedef struct packed {
    logic                  valid;
    logic                  done;
    logic [ROB_AREG_W-1:0] areg;
    logic [ROB_DATA_W-1:0] data;
  } rob_entry_t;

endpackage

// File: rtl/rob_retire_select.sv
// Counts the leading run of ready entries at the retire head.
module rob_retire_select #(
  parameter int unsigned WIDTH = 4,
  localparam int unsigned KW = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] ready,
  output logic [KW-1:0]    k
);

  logic run;

  always_comb begin
    k   = '0;
    run = 1'b1;
    for (int i = 0; i < int'(WIDTH); i++) begin
      run = run & ready[i];
      if (run) k = KW'(i + 1);
    end
  end

endmodule

// File: rtl/rob_multiport.sv
// Parametrised reorder buffer: in-order allocate, out-of-order complete,
// in-order multi-lane retire with registered write ports, flush and lookups.
module rob_multiport
  import rob_pkg::*;
#(
  parameter int unsigned DEPTH      = ROB_DEPTH,
  parameter int unsigned DATA_W     = ROB_DATA_W,
  parameter int unsigned AREG_W     = ROB_AREG_W,
  parameter int unsigned DISPATCH_W = 4,
  parameter int unsigned COMPLETE_W = 4,
  parameter int unsigned RETIRE_W   = 4,
  parameter int unsigned RD_PORTS   = 2,
  localparam int unsigned IW = $clog2(DEPTH),
  localparam int unsigned NW = $clog2(DISPATCH_W + 1)
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NW-1:0]                        disp_num,
  input  logic [DISPATCH_W-1:0][AREG_W-1:0]    disp_areg,
  output logic                                 disp_ready,
  output logic [DISPATCH_W-1:0][IW-1:0]        disp_tag,
  input  logic [COMPLETE_W-1:0]                cmp_valid,
  input  logic [COMPLETE_W-1:0][IW-1:0]        cmp_tag,
  input  logic [COMPLETE_W-1:0][DATA_W-1:0]    cmp_data,
  input  logic [RD_PORTS-1:0][IW-1:0]          rd_tag,
  output logic [RD_PORTS-1:0]                  rd_done,
  output logic [RD_PORTS-1:0][DATA_W-1:0]      rd_data,
  input  logic                                 flush,
  output logic [RETIRE_W-1:0]                  ret_valid,
  output logic [RETIRE_W-1:0][AREG_W-1:0]      ret_areg,
  output logic [RETIRE_W-1:0][DATA_W-1:0]      ret_data,
  output logic [RETIRE_W-1:0][IW-1:0]          ret_tag,
  output logic [IW:0]                          count,
  output logic                                 empty,
  output logic                                 full
);

  localparam int unsigned PW = IW + 1;
  localparam int unsigned KW = $clog2(RETIRE_W + 1);

  logic [PW-1:0]     alloc_ptr_q, alloc_ptr_d, ret_ptr_q, ret_ptr_d, free_cnt;
  logic [DEPTH-1:0]  valid_q, valid_d, done_q, done_d, retiring;
  logic [AREG_W-1:0] areg_q [DEPTH];
  logic [AREG_W-1:0] areg_d [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [IW-1:0]     ret_idx [RETIRE_W];
  logic [RETIRE_W-1:0] ret_ready, ret_valid_d;
  logic [RETIRE_W-1:0][AREG_W-1:0] ret_areg_d;
  logic [RETIRE_W-1:0][DATA_W-1:0] ret_data_d;
  logic [RETIRE_W-1:0][IW-1:0]     ret_tag_d;
  logic [KW-1:0]     ret_k;
  logic              disp_accept;

  // Pointers carry a wrap bit, so plain subtraction yields 0..DEPTH.
  assign count       = alloc_ptr_q - ret_ptr_q;
  assign empty       = (count == '0);
  assign full        = (count == PW'(DEPTH));
  assign free_cnt    = PW'(DEPTH) - count;
  assign disp_ready  = (int'(disp_num) <= int'(free_cnt));
  assign disp_accept = (disp_num != '0) && disp_ready;

  always_comb begin
    for (int i = 0; i < int'(DISPATCH_W); i++) disp_tag[i] = alloc_ptr_q[IW-1:0] + IW'(i);
    for (int i = 0; i < int'(RETIRE_W); i++) ret_idx[i] = ret_ptr_q[IW-1:0] + IW'(i);
  end

  always_comb begin
    for (int i = 0; i < int'(RETIRE_W); i++) begin
      ret_ready[i] = valid_q[ret_idx[i]] & done_q[ret_idx[i]] & (i < int'(count));
    end
  end

  rob_retire_select #(
    .WIDTH(RETIRE_W)
  ) u_retire_select (
    .ready(ret_ready),
    .k    (ret_k)
  );

  always_comb begin
    for (int p = 0; p < int'(RD_PORTS); p++) begin
      rd_done[p] = valid_q[rd_tag[p]] & done_q[rd_tag[p]];
      rd_data[p] = data_q[rd_tag[p]];
    end
  end

  always_comb begin
    valid_d     = valid_q;
    done_d      = done_q;
    areg_d      = areg_q;
    data_d      = data_q;
    alloc_ptr_d = alloc_ptr_q;
    ret_ptr_d   = ret_ptr_q;
    ret_valid_d = '0;
    ret_areg_d  = ret_areg;
    ret_data_d  = ret_data;
    ret_tag_d   = ret_tag;
    retiring    = '0;
    for (int i = 0; i < int'(RETIRE_W); i++) begin
      if (i < int'(ret_k)) retiring[ret_idx[i]] = 1'b1;
    end
    if (flush) begin
      valid_d     = '0;
      alloc_ptr_d = ret_ptr_q;
    end else begin
      // Ascending lane order lets the highest lane win on duplicate tags.
      for (int j = 0; j < int'(COMPLETE_W); j++) begin
        if (cmp_valid[j] && valid_q[cmp_tag[j]] && !retiring[cmp_tag[j]]) begin
          done_d[cmp_tag[j]] = 1'b1;
          data_d[cmp_tag[j]] = cmp_data[j];
        end
      end
      for (int i = 0; i < int'(RETIRE_W); i++) begin
        if (i < int'(ret_k)) begin
          valid_d[ret_idx[i]] = 1'b0;
          ret_valid_d[i]      = 1'b1;
          ret_areg_d[i]       = areg_q[ret_idx[i]];
          ret_data_d[i]       = data_q[ret_idx[i]];
          ret_tag_d[i]        = ret_idx[i];
        end
      end
      ret_ptr_d = ret_ptr_q + PW'(ret_k);
      if (disp_accept) begin
        for (int i = 0; i < int'(DISPATCH_W); i++) begin
          if (i < int'(disp_num)) begin
            valid_d[disp_tag[i]] = 1'b1;
            done_d[disp_tag[i]]  = 1'b0;
            areg_d[disp_tag[i]]  = disp_areg[i];
          end
        end
        alloc_ptr_d = alloc_ptr_q + PW'(disp_num);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alloc_ptr_q <= '0;
      ret_ptr_q   <= '0;
      valid_q     <= '0;
      done_q      <= '0;
      ret_valid   <= '0;
      ret_areg    <= '0;
      ret_data    <= '0;
      ret_tag     <= '0;
    end else begin
      alloc_ptr_q <= alloc_ptr_d;
      ret_ptr_q   <= ret_ptr_d;
      valid_q     <= valid_d;
      done_q      <= done_d;
      ret_valid   <= ret_valid_d;
      ret_areg    <= ret_areg_d;
      ret_data    <= ret_data_d;
      ret_tag     <= ret_tag_d;
    end
  end

  // Entry payload is intentionally left out of reset.
  always_ff @(posedge clk) begin
    areg_q <= areg_d;
    data_q <= data_d;
  end

endmodule

// File: tb/tb_rob_multiport.sv
// Scoreboard bench for rob_multiport: directed scenarios then random traffic
// against a counter/array reference model.
module tb_rob_multiport;
  import rob_pkg::*;

  localparam int D = 16, DW = 4, CW = 4, RW = 4, RP = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic [2:0]            disp_num;
  logic [DW-1:0][3:0]    disp_areg;
  logic                  disp_ready;
  logic [DW-1:0][3:0]    disp_tag;
  logic [CW-1:0]         cmp_valid;
  logic [CW-1:0][3:0]    cmp_tag;
  logic [CW-1:0][15:0]   cmp_data;
  logic [RP-1:0][3:0]    rd_tag;
  logic [RP-1:0]         rd_done;
  logic [RP-1:0][15:0]   rd_data;
  logic                  flush;
  logic [RW-1:0]         ret_valid;
  logic [RW-1:0][3:0]    ret_areg;
  logic [RW-1:0][15:0]   ret_data;
  logic [RW-1:0][3:0]    ret_tag;
  logic [4:0]            count;
  logic                  empty, full;

  always #5 clk = ~clk;

  rob_multiport dut (
    .clk(clk), .rst_n(rst_n),
    .disp_num(disp_num), .disp_areg(disp_areg), .disp_ready(disp_ready), .disp_tag(disp_tag),
    .cmp_valid(cmp_valid), .cmp_tag(cmp_tag), .cmp_data(cmp_data),
    .rd_tag(rd_tag), .rd_done(rd_done), .rd_data(rd_data),
    .flush(flush),
    .ret_valid(ret_valid), .ret_areg(ret_areg), .ret_data(ret_data), .ret_tag(ret_tag),
    .count(count), .empty(empty), .full(full)
  );

  typedef struct {
    logic               disp_ready;
    logic [DW-1:0][3:0] disp_tag;
    int                 count;
    logic               empty, full;
    logic [RP-1:0]      rd_done;
    logic [RP-1:0][15:0] rd_data;
    logic [RP-1:0]      rd_known;
    logic [RW-1:0]      ret_valid;
  } exp_t;

  typedef struct {
    logic [3:0]  areg;
    logic [15:0] data;
    int          tag;
  } ret_t;

  exp_t exp_q[$];
  ret_t ret_q[$];

  // Reference model: unbounded allocation/retire counters, slot = counter mod D.
  int          alloc_c, ret_c;
  bit          mvalid [D];
  bit          mdone  [D];
  bit          mhas   [D];
  logic [3:0]  mareg  [D];
  logic [15:0] mdata  [D];
  logic [RW-1:0] exp_ret_valid;

  int n_chk = 0, n_pass = 0;

  function automatic void check(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endfunction

  function automatic int head(int i);
    return (ret_c + i) % D;
  endfunction

  task automatic model_reset();
    alloc_c = 0;
    ret_c   = 0;
    exp_ret_valid = '0;
    for (int i = 0; i < D; i++) begin
      mvalid[i] = 0;
      mdone[i]  = 0;
    end
    exp_q.delete();
    ret_q.delete();
  endtask

  task automatic model_edge();
    int cnt, k, t, off, n;
    ret_t r;
    if (!rst_n) begin
      model_reset();
      return;
    end
    cnt = alloc_c - ret_c;
    if (flush) begin
      for (int i = 0; i < D; i++) mvalid[i] = 0;
      alloc_c = ret_c;
      exp_ret_valid = '0;
      return;
    end
    k = 0;
    for (int i = 0; i < RW; i++) begin
      if (i < cnt && mvalid[head(i)] && mdone[head(i)]) k++;
      else break;
    end
    for (int j = 0; j < CW; j++) begin
      if (cmp_valid[j]) begin
        t   = int'(cmp_tag[j]);
        off = (t - head(0) + D) % D;
        if (mvalid[t] && !(off < k)) begin
          mdone[t] = 1;
          mdata[t] = cmp_data[j];
          mhas[t]  = 1;
        end
      end
    end
    n = int'(disp_num);
    if (n != 0 && n <= D - cnt) begin
      for (int i = 0; i < n; i++) begin
        mvalid[(alloc_c + i) % D] = 1;
        mdone[(alloc_c + i) % D]  = 0;
        mareg[(alloc_c + i) % D]  = disp_areg[i];
      end
      alloc_c += n;
    end
    for (int i = 0; i < k; i++) begin
      r.areg = mareg[head(0)];
      r.data = mdata[head(0)];
      r.tag  = head(0);
      ret_q.push_back(r);
      mvalid[head(0)] = 0;
      ret_c++;
    end
    exp_ret_valid = RW'((1 << k) - 1);
  endtask

  task automatic push_expect();
    exp_t e;
    int cnt, t;
    cnt = alloc_c - ret_c;
    e.disp_ready = (int'(disp_num) <= D - cnt);
    for (int i = 0; i < DW; i++) e.disp_tag[i] = 4'((alloc_c + i) % D);
    e.count = cnt;
    e.empty = (cnt == 0);
    e.full  = (cnt == D);
    for (int p = 0; p < RP; p++) begin
      t = int'(rd_tag[p]);
      e.rd_done[p]  = mvalid[t] && mdone[t];
      e.rd_data[p]  = mdata[t];
      e.rd_known[p] = mhas[t];
    end
    e.ret_valid = exp_ret_valid;
    exp_q.push_back(e);
  endtask

  task automatic idle();
    disp_num  = '0;
    for (int i = 0; i < DW; i++) disp_areg[i] = 4'($urandom_range(0, 15));
    cmp_valid = '0;
    cmp_tag   = '0;
    cmp_data  = '0;
    flush     = 1'b0;
    for (int p = 0; p < RP; p++) rd_tag[p] = 4'($urandom_range(0, 15));
  endtask

  // Inputs are set before calling; returns 1 time unit after the next rising edge.
  task automatic cyc();
    push_expect();
    @(posedge clk);
    model_edge();
    #1;
    idle();
  endtask

  task automatic cmp_lane(int j, int tag, logic [15:0] d);
    cmp_valid[j] = 1'b1;
    cmp_tag[j]   = 4'(tag);
    cmp_data[j]  = d;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      ret_t r;
      e = exp_q.pop_front();
      check("disp_ready", disp_ready, e.disp_ready);
      check("disp_tag", disp_tag, e.disp_tag);
      check("count", count, e.count);
      check("empty", empty, e.empty);
      check("full", full, e.full);
      check("rd_done", rd_done, e.rd_done);
      for (int p = 0; p < RP; p++) if (e.rd_known[p]) check("rd_data", rd_data[p], e.rd_data[p]);
      check("ret_valid", ret_valid, e.ret_valid);
      for (int i = 0; i < RW; i++) begin
        if (ret_valid[i]) begin
          if (ret_q.size() == 0) check("ret_unexpected", ret_valid[i], 0);
          else begin
            r = ret_q.pop_front();
            check("ret_areg", ret_areg[i], r.areg);
            check("ret_data", ret_data[i], r.data);
            check("ret_tag", ret_tag[i], r.tag);
          end
        end
      end
    end
  end

  initial begin
    int n, keep_tag, cnt;
    rst_n = 1'b0;
    for (int i = 0; i < D; i++) mhas[i] = 0;
    model_reset();
    idle();
    #6;
    rst_n = 1'b1;

    // Initial dispatch of areg 1..4.
    disp_num = 3'd4;
    for (int i = 0; i < 4; i++) disp_areg[i] = 4'(i + 1);
    cyc();
    // Out-of-order completions; tag 2 waits for tag 1.
    cmp_lane(0, 2, 16'hAAAA);
    cyc();
    cmp_lane(0, 0, 16'hBBBB);
    cyc();
    cyc();
    cmp_lane(0, 1, 16'hCCCC);
    cyc();
    cyc();

    // Fill, refuse when full, then free three and wrap.
    while (alloc_c - ret_c < D) begin
      n = D - (alloc_c - ret_c);
      disp_num = 3'((n > 4) ? 4 : n);
      cyc();
    end
    disp_num = 3'd1;
    cyc();
    for (int j = 0; j < 3; j++) cmp_lane(j, head(j), 16'(16'h3000 + j));
    cyc();
    cyc();
    disp_num = 3'd3;
    cyc();

    // Simultaneous dispatch, duplicate-tag completion and 4-wide retire.
    for (int j = 0; j < 4; j++) cmp_lane(j, head(j), 16'(16'h4000 + j));
    cyc();
    for (int j = 0; j < 4; j++) cmp_lane(j, head(j + 4), 16'(16'h5000 + j));
    cyc();
    keep_tag = head(4);
    disp_num = 3'd2;
    cmp_lane(0, keep_tag, 16'h1111);
    cmp_lane(1, keep_tag, 16'h2222);
    cyc();
    rd_tag[0] = 4'(keep_tag);
    cyc();

    // Flush with seven live entries and a completion offered.
    flush = 1'b1;
    cyc();
    disp_num = 3'd4;
    cyc();
    disp_num = 3'd3;
    cyc();
    flush = 1'b1;
    cmp_lane(0, head(1), 16'hDEAD);
    cyc();
    rd_tag[0] = 4'(head(0));
    rd_tag[1] = 4'(head(6));
    cyc();

    // Asynchronous reset while four lanes are retiring.
    disp_num = 3'd4;
    cyc();
    for (int j = 0; j < 4; j++) cmp_lane(j, head(j), 16'(16'h6000 + j));
    cyc();
    cyc();
    check("pre_reset_ret_valid", ret_valid, 4'hF);
    rst_n = 1'b0;
    #1;
    check("async_ret_valid", ret_valid, 0);
    check("async_count", count, 0);
    check("async_empty", empty, 1);
    model_reset();
    cyc();
    rst_n = 1'b1;
    cyc();

    // Random traffic.
    for (int c = 0; c < 1500; c++) begin
      cnt = alloc_c - ret_c;
      disp_num = 3'($urandom_range(0, 4));
      for (int j = 0; j < CW; j++) begin
        if ($urandom_range(0, 2) != 0) begin
          if (cnt > 0 && $urandom_range(0, 7) != 0) n = head($urandom_range(0, cnt - 1));
          else n = $urandom_range(0, D - 1);
          cmp_lane(j, n, 16'($urandom));
        end
      end
      flush = ($urandom_range(0, 59) == 0);
      cyc();
    end

    for (int c = 0; c < 3; c++) cyc();
    @(negedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);
    check("retire_queue_drained", ret_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
